instr_fetch: RTL and testbench

//   Instruction-fetch initiator paired with instr_mem: owns the PC, drives imem_addr, captures
//   the returned word and queues {pc, instr} in a small FIFO toward decode with valid/ready flow

---
 rtl/instr_fetch.sv | 153 +++++++++++++++
 tb/tb_instr_fetch.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch -- instruction-fetch initiator for the MIPS pipeline.
//
// Owns the program counter and drives it to instr_mem. The instruction word
// comes back combinationally in the same cycle. Each fetched {pc, instr}
// pair is queued in a small FIFO toward decode, with valid/ready flow control.
// A redirect from execute (taken branch or jump) flushes every queued
// wrong-path entry and reloads the PC.
//
// Optional feature: define IFETCH_HALT_EN to add a HALT state. In that build,
// fetching the syscall word 32'h0000_000C enqueues it normally and then
// stops fetching until the next redirect. Without the macro the FSM has only
// the IDLE and RUN states, and a syscall is fetched like any other word.
//
// Ports:
//   clk            in   1       rising-edge clock
//   rst_n          in   1       asynchronous active-low reset
//   imem_addr      out  ADDR_W  byte address to instr_mem (always the PC)
//   imem_en        out  1       fetch request this cycle (equals push)
//   imem_rdata     in   DATA_W  instruction word for imem_addr, same cycle
//   redirect_valid in   1       branch/jump taken, 1-cycle pulse
//   redirect_pc    in   ADDR_W  new PC; bits [1:0] are ignored
//   out_valid      out  1       FIFO head valid
//   out_ready      in   1       decode accepts the head
//   out_instr      out  DATA_W  head instruction (0 while the FIFO is empty)
//   out_pc         out  ADDR_W  head PC (0 while the FIFO is empty)
// ---------------------------------------------------------------------------
module instr_fetch #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_en,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

`ifdef IFETCH_HALT_EN
    localparam logic [DATA_W-1:0] SYSCALL_WORD = DATA_W'(32'h0000_000C);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0]  fifoPc_q    [FIFO_DEPTH];
    logic [DATA_W-1:0]  fifoInstr_q [FIFO_DEPTH];

    logic push;
    logic pop;

    // Handshake and request generation. When the FIFO is full, a push is
    // still allowed in a cycle that also pops, so throughput stays at one
    // instruction per cycle.
    always_comb begin
        out_valid = (count_q != '0);
        pop       = out_valid & out_ready;
        push      = (state_q == RUN) & ~redirect_valid
                    & ((count_q < CNT_W'(FIFO_DEPTH)) | pop);
        imem_en   = push;
        imem_addr = pc_q;
        out_pc    = out_valid ? fifoPc_q[rdPtr_q]    : '0;
        out_instr = out_valid ? fifoInstr_q[rdPtr_q] : '0;
    end

    // Next-state logic. A redirect overrides everything else: it flushes
    // the FIFO (a coincident pop goes with it), reloads the PC and resumes
    // RUN from any state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        if (redirect_valid) begin
            state_d = RUN;
            pc_d    = redirect_pc & ~ADDR_W'(3);
            count_d = '0;
            rdPtr_d = '0;
            wrPtr_d = '0;
        end else begin
            case (state_q)
                IDLE: state_d = RUN;
`ifdef IFETCH_HALT_EN
                RUN: begin
                    if (push && (imem_rdata == SYSCALL_WORD)) begin
                        state_d = HALT;
                    end
                end
`endif
                default: state_d = state_q;
            endcase
            if (push) begin
                pc_d    = pc_q + ADDR_W'(4);
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            count_q <= '0;
            rdPtr_q <= '0;
            wrPtr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
        end
    end

    // FIFO storage needs no reset. Stale slots are never visible because
    // the outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoPc_q[wrPtr_q]    <= pc_q;
            fifoInstr_q[wrPtr_q] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch -- scoreboard bench for instr_fetch.
//
// A behavioural model treats the fetch queue as a bounded SystemVerilog
// queue of {pc, instr} entries. When the model decides a fetch happens, it
// pushes the expected entry. A separate monitor checks the request side
// every cycle. On every decode handshake it pops the expected entry and
// compares it with the DUT's head.
//
// The instruction memory returns 0x1000_0000 + word index. The exception is
// SYS_ADDR, which holds the syscall word 0x0000_000C. That word only stops
// fetching when IFETCH_HALT_EN is defined.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] SYS_ADDR = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    entry_t      expQ[$];
    logic [31:0] modelPc = RESET_PC;
    int          modelState = 0;
    int          checks = 0;
    int          errors = 0;
    int          handshakes = 0;

    instr_fetch #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if (addr == SYS_ADDR) return 32'h0000_000C;
        return 32'h1000_0000 + {2'b00, addr[31:2]};
    endfunction

    // Combinational instruction memory: it answers in the same cycle.
    assign imem_rdata = memWord(imem_addr);

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference model. The model states are 0 = idle, 1 = running and
    // 2 = halted. At each edge it applies the fetch rules:
    //   - A redirect empties the queue and jumps the PC.
    //   - Otherwise a running fetcher appends {pc, mem[pc]} while the queue
    //     has room. The monitor has already removed this cycle's consumed
    //     head, so "room" already includes the same-cycle pop.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                expQ.delete();
                modelPc    = RESET_PC;
                modelState = 0;
            end else if (redirect_valid) begin
                expQ.delete();
                modelPc    = redirect_pc & ~32'h3;
                modelState = 1;
            end else if (modelState == 0) begin
                modelState = 1;
            end else if (modelState == 1 && expQ.size() < DEPTH) begin
                expQ.push_back({modelPc, memWord(modelPc)});
`ifdef IFETCH_HALT_EN
                if (memWord(modelPc) == 32'h0000_000C) modelState = 2;
`endif
                modelPc = modelPc + 32'd4;
            end
        end
    end

    // Monitor. On each falling edge it checks the request side and the
    // presence of a head. While a head is valid it checks the head against
    // the scoreboard, which also catches a head that changes during a
    // stall. It retires the expected entry on a handshake.
    initial begin
        bit expValid;
        bit expEn;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                expValid = (expQ.size() > 0);
                expEn    = (modelState == 1) && !redirect_valid
                           && ((expQ.size() < DEPTH) || (expValid && out_ready));
                checkOutput("imem_addr", 64'(imem_addr), 64'(modelPc));
                checkOutput("imem_en", 64'(imem_en), 64'(expEn));
                checkOutput("out_valid", 64'(out_valid), 64'(expValid));
                if (expValid && out_valid) begin
                    checkOutput("out_pc", 64'(out_pc), 64'(expQ[0].pc));
                    checkOutput("out_instr", 64'(out_instr), 64'(expQ[0].instr));
                    if (out_ready) begin
                        expQ.delete(0);
                        handshakes++;
                    end
                end
            end
        end
    end

    // Drives one cycle of inputs just after the rising edge.
    task automatic applyStimulus(input bit rdy, input bit redir,
                                 input logic [31:0] rpc);
        @(posedge clk);
        #1;
        out_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
    endtask

    // Holds reset for two edges, checks the reset values, then releases
    // reset between edges.
    task automatic applyReset();
        #2;
        rst_n          = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_imem_en", 64'(imem_en), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_pc", 64'(out_pc), 64'd0);
        checkOutput("rst_out_instr", 64'(out_instr), 64'd0);
        checkOutput("rst_imem_addr", 64'(imem_addr), 64'(RESET_PC));
        #1;
        rst_n = 1'b1;
    endtask

    // Main sequence: directed scenarios first, then random traffic, then
    // an asynchronous reset in the middle of the stream.
    initial begin
        applyReset();

        // Streaming at full rate from the reset PC.
        repeat (20) applyStimulus(1'b1, 1'b0, '0);

        // Backpressure: the queue fills, then drains in order.
        repeat (5) applyStimulus(1'b0, 1'b0, '0);
        repeat (5) applyStimulus(1'b1, 1'b0, '0);

        // Redirect with an unaligned target while the queue is full.
        repeat (3) applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 32'h0000_0043);
        repeat (4) applyStimulus(1'b1, 1'b0, '0);

        // PC wrap past the top of the address space.
        applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (6) applyStimulus(1'b1, 1'b0, '0);

        // Run through the syscall word, then redirect away.
        applyStimulus(1'b1, 1'b1, 32'h0000_00F8);
        repeat (8) applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 32'h0000_0020);
        repeat (4) applyStimulus(1'b1, 1'b0, '0);

        // Random ready and redirect traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 511));
            applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, rpc);
        end
        applyStimulus(1'b1, 1'b0, '0);
        repeat (3) applyStimulus(1'b1, 1'b0, '0);

        // Asynchronous reset between clock edges, then a restart.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_out_valid", 64'(out_valid), 64'd0);
        checkOutput("async_imem_addr", 64'(imem_addr), 64'(RESET_PC));
        checkOutput("async_imem_en", 64'(imem_en), 64'd0);
        out_ready      = 1'b1;
        redirect_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (12) applyStimulus(1'b1, 1'b0, '0);

        checkOutput("handshakes_min", 64'(handshakes >= 150), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
